// File: rtl/pc_fetch_sequencer.sv
// Program counter and fetch-request sequencer with a valid/ack handshake and redirect capture.
// A request holds its address until ack; a redirect that arrives mid-request is held until that ack.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic        IMemAck,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  output logic [31:0] PCResult,
  output logic [31:0] PCAddResult,
  output logic        InstrValid,
  output logic [31:0] FetchedPC
);

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_STALL} state_e;

  state_e      state_q, state_d;
  logic        arm_q, arm_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_vld_q, pend_vld_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic        instr_vld_q, instr_vld_d;
  logic [31:0] fetched_pc_q, fetched_pc_d;

  logic        redir;
  logic [31:0] redir_raw;
  logic [31:0] redir_tgt;
  logic [31:0] pc_add;

  assign redir     = Jump | BranchTaken;
  assign redir_raw = Jump ? JumpTarget : BranchTarget;
  assign redir_tgt = {redir_raw[31:2], 2'b00};
  assign pc_add    = pc_q + 32'd4;

  always_comb begin
    state_d      = state_q;
    arm_d        = arm_q;
    pc_d         = pc_q;
    pend_vld_d   = pend_vld_q;
    pend_tgt_d   = pend_tgt_q;
    instr_vld_d  = 1'b0;
    fetched_pc_d = fetched_pc_q;
    case (state_q)
      // arm_q absorbs the first edge after release so BOOT spans one full cycle.
      S_BOOT: begin
        arm_d = 1'b1;
        if (arm_q) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (IMemAck) begin
          if (redir) begin
            pc_d = redir_tgt;
          end else if (pend_vld_q) begin
            pc_d = pend_tgt_q;
          end else begin
            pc_d         = pc_add;
            instr_vld_d  = 1'b1;
            fetched_pc_d = pc_q;
          end
          pend_vld_d = 1'b0;
          state_d    = Stall ? S_STALL : S_FETCH;
        end else if (redir) begin
          pend_vld_d = 1'b1;
          pend_tgt_d = redir_tgt;
        end
      end
      S_STALL: begin
        if (redir)  pc_d    = redir_tgt;
        if (!Stall) state_d = S_FETCH;
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= S_BOOT;
      arm_q        <= 1'b0;
      pc_q         <= RESET_PC;
      pend_vld_q   <= 1'b0;
      pend_tgt_q   <= 32'h0;
      instr_vld_q  <= 1'b0;
      fetched_pc_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      arm_q        <= arm_d;
      pc_q         <= pc_d;
      pend_vld_q   <= pend_vld_d;
      pend_tgt_q   <= pend_tgt_d;
      instr_vld_q  <= instr_vld_d;
      fetched_pc_q <= fetched_pc_d;
    end
  end

  assign IMemReq     = (state_q == S_FETCH);
  assign IMemAddr    = pc_q;
  assign PCResult    = pc_q;
  assign PCAddResult = pc_add;
  assign InstrValid  = instr_vld_q;
  assign FetchedPC   = fetched_pc_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed scenarios then random traffic against a transaction-level model.
module tb_pc_fetch_sequencer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Stall = 1'b0;
  logic        BranchTaken = 1'b0;
  logic [31:0] BranchTarget = 32'h0;
  logic        Jump = 1'b0;
  logic [31:0] JumpTarget = 32'h0;
  logic        IMemAck = 1'b0;
  logic        IMemReq, InstrValid;
  logic [31:0] IMemAddr, PCResult, PCAddResult, FetchedPC;

  logic        rst2_n = 1'b0;
  logic        req2, iv2;
  logic [31:0] addr2, pc2, pcadd2, fpc2;

  int checks = 0;
  int failures = 0;

  // Reference model: request outstanding / stalled / booting, with a one-deep pending-target queue.
  int          m_boot_left;
  bit          m_req;
  logic [31:0] m_pc;
  logic [31:0] m_pend[$];
  bit          m_iv;
  logic [31:0] m_fpc;

  always #5 Clk = ~Clk;

  pc_fetch_sequencer u_dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .Jump(Jump), .JumpTarget(JumpTarget), .IMemAck(IMemAck), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
    .PCResult(PCResult), .PCAddResult(PCAddResult), .InstrValid(InstrValid), .FetchedPC(FetchedPC)
  );

  pc_fetch_sequencer #(.RESET_PC(32'hFFFF_FFFF)) u_dut_wrap (
    .Clk(Clk), .Reset(rst2_n), .Stall(Stall), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .Jump(Jump), .JumpTarget(JumpTarget), .IMemAck(IMemAck), .IMemReq(req2), .IMemAddr(addr2),
    .PCResult(pc2), .PCAddResult(pcadd2), .InstrValid(iv2), .FetchedPC(fpc2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_boot_left = 2;
    m_req       = 1'b0;
    m_pc        = 32'h0;
    m_pend.delete();
    m_iv        = 1'b0;
    m_fpc       = 32'h0;
  endtask

  task automatic model_step();
    logic [31:0] tgt;
    bit          rd;
    rd   = Jump || BranchTaken;
    tgt  = (Jump ? JumpTarget : BranchTarget) & 32'hFFFF_FFFC;
    m_iv = 1'b0;
    if (!Reset) begin
      model_reset();
    end else if (m_boot_left > 0) begin
      m_boot_left--;
      if (m_boot_left == 0) m_req = 1'b1;
    end else if (m_req) begin
      if (IMemAck) begin
        if (rd) m_pc = tgt;
        else if (m_pend.size() > 0) m_pc = m_pend[0];
        else begin
          m_fpc = m_pc;
          m_iv  = 1'b1;
          m_pc  = m_pc + 32'd4;
        end
        m_pend.delete();
        m_req = !Stall;
      end else if (rd) begin
        m_pend.delete();
        m_pend.push_back(tgt);
      end
    end else begin
      if (rd) m_pc = tgt;
      if (!Stall) m_req = 1'b1;
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".req"}, {31'h0, IMemReq}, {31'h0, m_req});
    chk({tag, ".addr"}, IMemAddr, m_pc);
    chk({tag, ".pc"}, PCResult, m_pc);
    chk({tag, ".pcadd"}, PCAddResult, m_pc + 32'd4);
    chk({tag, ".iv"}, {31'h0, InstrValid}, {31'h0, m_iv});
    if (m_iv) chk({tag, ".fpc"}, FetchedPC, m_fpc);
  endtask

  // Inputs are driven at the falling edge; the model advances with the DUT's rising edge.
  task automatic tick(input string tag);
    model_step();
    @(posedge Clk);
    @(negedge Clk);
    compare_all(tag);
  endtask

  task automatic set_in(input bit st, input bit ack, input bit jp, input logic [31:0] jt,
                        input bit br, input logic [31:0] bt);
    Stall = st; IMemAck = ack; Jump = jp; JumpTarget = jt; BranchTaken = br; BranchTarget = bt;
  endtask

  initial begin
    model_reset();
    @(negedge Clk);
    tick("rst");
    chk("rst.fpc", FetchedPC, 32'h0);
    chk("wrap.pc", pc2, 32'hFFFF_FFFF);
    chk("wrap.pcadd", pcadd2, 32'h0000_0003);

    // Sequential fetch with ack tied high.
    Reset = 1'b1;
    set_in(0, 1, 0, 0, 0, 0);
    tick("boot1");
    chk("boot1.noreq", {31'h0, IMemReq}, 32'h0);
    tick("boot2");
    chk("seq.addr0", IMemAddr, 32'h0);
    for (int i = 0; i < 4; i++) tick("seq");
    chk("seq.addr16", IMemAddr, 32'h10);
    chk("seq.fpc12", FetchedPC, 32'hC);

    // Redirect to 0x20, then a three-cycle ack delay.
    set_in(0, 0, 1, 32'h20, 0, 0);
    tick("pend20");
    set_in(0, 1, 0, 0, 0, 0);
    tick("take20");
    chk("take20.noiv", {31'h0, InstrValid}, 32'h0);
    set_in(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick("wait20");
      chk("wait20.addr", IMemAddr, 32'h20);
    end
    set_in(0, 1, 0, 0, 0, 0);
    tick("ack20");
    chk("ack20.pc", PCResult, 32'h24);
    chk("ack20.fpc", FetchedPC, 32'h20);

    // Branch while waiting, ack two cycles later.
    set_in(0, 0, 0, 0, 1, 32'h100);
    tick("br100");
    set_in(0, 0, 0, 0, 0, 0);
    tick("br100w");
    set_in(0, 1, 0, 0, 0, 0);
    tick("br100a");
    chk("br100.pc", PCResult, 32'h100);
    chk("br100.noiv", {31'h0, InstrValid}, 32'h0);

    // Same-cycle jump and branch; jump wins. Then an unaligned target.
    set_in(0, 1, 1, 32'h200, 1, 32'h300);
    tick("prio");
    chk("prio.pc", PCResult, 32'h200);
    set_in(0, 1, 0, 0, 1, 32'h103);
    tick("align");
    chk("align.pc", PCResult, 32'h100);

    // Wrap at the top of the address space.
    set_in(0, 1, 1, 32'hFFFF_FFFC, 0, 0);
    tick("top");
    set_in(0, 1, 0, 0, 0, 0);
    tick("wrap");
    chk("wrap.pc0", PCResult, 32'h0);
    chk("wrap.pcadd4", PCAddResult, 32'h4);

    // Stall raised during an outstanding request, jump while stalled, release.
    set_in(1, 0, 0, 0, 0, 0);
    tick("stw");
    chk("stw.req", {31'h0, IMemReq}, 32'h1);
    set_in(1, 1, 0, 0, 0, 0);
    tick("stack");
    chk("stack.iv", {31'h0, InstrValid}, 32'h1);
    chk("stack.noreq", {31'h0, IMemReq}, 32'h0);
    set_in(1, 0, 1, 32'h40, 0, 0);
    tick("stjmp");
    chk("stjmp.pc", PCResult, 32'h40);
    set_in(0, 0, 0, 0, 0, 0);
    tick("strel");
    chk("strel.req", {31'h0, IMemReq}, 32'h1);
    chk("strel.addr", IMemAddr, 32'h40);

    // Asynchronous reset in the middle of a request.
    tick("prerst");
    @(posedge Clk);
    #2;
    Reset = 1'b0;
    #1;
    chk("arst.req", {31'h0, IMemReq}, 32'h0);
    chk("arst.pc", PCResult, 32'h0);
    model_reset();
    @(negedge Clk);
    IMemAck = 1'b1;
    tick("inrst");
    Reset = 1'b1;

    // Random traffic with occasional reset pulses.
    for (int i = 0; i < 400; i++) begin
      Stall        = ($urandom_range(0, 3) == 0);
      IMemAck      = ($urandom_range(0, 2) != 0);
      Jump         = ($urandom_range(0, 7) == 0);
      BranchTaken  = ($urandom_range(0, 5) == 0);
      JumpTarget   = $urandom;
      BranchTarget = $urandom;
      Reset        = ($urandom_range(0, 59) != 0);
      tick("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_fetch_sequencer.md
PC_FETCH_SEQUENCER -- requirements
Module: pc_fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, PC value loaded on reset.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-004 Stall  input  1  1 = issue no new fetch request.
REQ-005 BranchTaken  input  1  branch redirect request, valid in the cycle asserted.
REQ-006 BranchTarget  input  32  branch destination address.
REQ-007 Jump  input  1  jump redirect request, valid in the cycle asserted.
REQ-008 JumpTarget  input  32  jump destination address.
REQ-009 IMemAck  input  1  instruction memory accepts the current request this cycle.
REQ-010 IMemReq  output  1  fetch request to instruction memory.
REQ-011 IMemAddr  output  32  fetch address; always equals PCResult.
REQ-012 PCResult  output  32  current program counter, registered.
REQ-013 PCAddResult  output  32  PCResult + 4, combinational.
REQ-014 InstrValid  output  1  one-cycle pulse: a fetch completed and was not discarded.
REQ-015 FetchedPC  output  32  address of the completed fetch; qualified by InstrValid.

Function
REQ-016 State machine SHALL have three states: BOOT, FETCH, STALL; IMemReq = 1 only in FETCH.
REQ-017 BOOT SHALL last exactly one cycle after reset release, then go to FETCH.
REQ-018 Handshake: in FETCH, IMemReq and IMemAddr SHALL hold stable until the IMemAck cycle; a request is never withdrawn early.
REQ-019 Ack without redirect SHALL load PC <= PC + 4, FetchedPC <= old PC, and InstrValid = 1 for the next cycle only.
REQ-020 Redirect priority SHALL be Jump > BranchTaken > sequential.
REQ-021 Redirect target bits [1:0] SHALL be forced to 2'b00 when loaded.
REQ-022 Redirect in FETCH without ack SHALL be captured in a pending register (valid bit plus target); a later redirect overwrites the pending target.
REQ-023 On ack with a pending redirect or a same-cycle redirect:
  - PC SHALL load the redirect target, with same-cycle taking precedence over pending.
  - The fetched instruction SHALL be discarded, so InstrValid stays 0.
  - The pending register SHALL clear.
REQ-024 After ack:
  - Stall = 1 SHALL move to STALL.
  - Stall = 0 SHALL remain in FETCH, asserting a new request the next cycle at the new PC.
REQ-025 STALL SHALL return to FETCH the cycle after Stall = 0; a redirect in STALL loads PC directly, without using the pending register.
REQ-026 Stall asserted in FETCH before ack SHALL NOT affect the outstanding request.
REQ-027 PC arithmetic SHALL be modulo 2^32: PC 32'hFFFFFFFC + 4 = 32'h00000000, with no flag.
REQ-028 PCAddResult SHALL wrap identically: PCResult 32'hFFFFFFFF gives 32'h00000003.

Reset
REQ-029 Reset = 0 SHALL asynchronously set state BOOT, PCResult = RESET_PC, IMemReq = 0, InstrValid = 0, FetchedPC = 0, and pending clear.
REQ-030 Reset asserted mid-handshake SHALL drop IMemReq immediately; any ack during reset is ignored.
REQ-031 Deassertion SHALL take effect at the next rising Clk edge; the first request is issued two edges after release.

Verification
REQ-032 Reset release, IMemAck tied 1, Stall 0 -> IMemAddr sequence 0, 4, 8, 12; InstrValid pulses with FetchedPC 0, 4, 8.
REQ-033 Ack delayed 3 cycles at PC 32'h20 -> IMemReq high and IMemAddr 32'h20 stable for 4 cycles; then PC 32'h24.
REQ-034 Pending and same-cycle redirects:
  - BranchTaken with target 32'h100 while waiting; ack 2 cycles later -> no InstrValid; next request at 32'h100.
  - Jump (32'h200) and BranchTaken (32'h300) in the same cycle -> 32'h200 wins.
  - Target 32'h103 -> PC 32'h100.
REQ-035 PC 32'hFFFFFFFC, ack -> PC 32'h00000000, PCAddResult 32'h00000004.
REQ-036 Stall and reset corner cases:
  - Stall = 1 during an outstanding request; ack -> InstrValid pulses; state STALL with IMemReq 0.
  - Jump to 32'h40 while stalled -> PC 32'h40; Stall release -> request at 32'h40.
  - Reset pulsed mid-request -> IMemReq low with no clock edge; PC = RESET_PC.
